// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg
// Shared definitions for the Tomasulo core: default bus widths, the
// station tag encoding and the value driven on the CDB data lines when no
// station is broadcasting.
// No ports; imported by cdb_arbiter and rr_picker.
package tomasulo_pkg;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 16;

  // Tag 0 means "no producer": an operand tagged FREE_REGISTER is
  // already valid, so a station can never legitimately broadcast it.
  typedef enum logic [TAG_W-1:0] {
    FREE_REGISTER    = 3'd0,
    RES_STATION_ADD1 = 3'd1,
    RES_STATION_ADD2 = 3'd2
  } station_tag_e;

  localparam logic [DATA_W-1:0] SEM_VALOR = 16'hFFF0;

  // Saturating increment used by the optional bus statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Combinational round-robin selector. Scans the eligible vector starting
// at index prio, wrapping from N_REQ-1 back to 0, and reports the first
// set bit.
// Ports:
//   eligible  in  N_REQ   one bit per requester allowed to win this cycle
//   prio      in  PRIO_W  index with highest priority this cycle
//   winner    out PRIO_W  index of the selected requester (0 if none)
//   found     out 1       at least one requester was eligible
module rr_picker
  import tomasulo_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int PRIO_W = 1
) (
  input  logic [N_REQ-1:0]  eligible,
  input  logic [PRIO_W-1:0] prio,
  output logic [PRIO_W-1:0] winner,
  output logic              found
);

  int                idx;
  logic [PRIO_W-1:0] idx_p;

  // Walk the offsets from farthest to nearest so the last hit written is
  // the one closest to prio, which is the round-robin winner.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idx_p  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(prio) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      idx_p = PRIO_W'(idx);
      if (eligible[idx_p]) begin
        winner = idx_p;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Round-robin arbiter and driver for the Common Data Bus. Each cycle one
// finished reservation station is chosen and its tag and result are
// broadcast, registered, for exactly one cycle to register_status and to
// every reservation station.
// Ports:
//   Clock           in   rising-edge clock
//   Reset           in   synchronous, active-high
//   Req             in   N_REQ        station i holds a finished result
//   Req_Tag         in   N_REQ*TAG_W  station i tag at [i*TAG_W +: TAG_W]
//   Req_Data        in   N_REQ*DATA_W station i result at [i*DATA_W +: DATA_W]
//   Grant           out  N_REQ        one-hot pulse to the broadcasting station
//   CDB_Valid       out  1            broadcast valid this cycle
//   Qi_CDB          out  TAG_W        broadcast tag, 0 when idle
//   Qi_CDB_data     out  DATA_W       broadcast value, IDLE_DATA when idle
//   Tag_Error       out  1            sticky: a request carried tag 0
// Optional (macro CDB_STATS_EN defined):
//   Bcast_Count     out  16           saturating count of broadcasts
//   Conflict_Count  out  16           saturating count of cycles with 2+ eligible requesters
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int                N_REQ     = 2,
  parameter int                TAG_W     = tomasulo_pkg::TAG_W,
  parameter int                DATA_W    = tomasulo_pkg::DATA_W,
  parameter logic [DATA_W-1:0] IDLE_DATA = SEM_VALOR
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [N_REQ-1:0]          Req,
  input  logic [N_REQ*TAG_W-1:0]    Req_Tag,
  input  logic [N_REQ*DATA_W-1:0]   Req_Data,
  output logic [N_REQ-1:0]          Grant,
  output logic                      CDB_Valid,
  output logic [TAG_W-1:0]          Qi_CDB,
  output logic [DATA_W-1:0]         Qi_CDB_data,
  output logic                      Tag_Error
`ifdef CDB_STATS_EN
  ,
  output logic [15:0]               Bcast_Count,
  output logic [15:0]               Conflict_Count
`endif
);

  localparam int PRIO_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PRIO_W-1:0] prio;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  tag_zero;
  logic [PRIO_W-1:0] winner;
  logic              found;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;

  // A station is skipped if its tag is FREE_REGISTER (a malformed request)
  // or if it was granted last cycle: it needs that cycle to see Grant and
  // drop Req, otherwise it would be broadcast twice.
  always_comb begin
    eligible = '0;
    tag_zero = '0;
    for (int i = 0; i < N_REQ; i++) begin
      tag_zero[i] = Req[i] && (Req_Tag[i*TAG_W +: TAG_W] == TAG_W'(FREE_REGISTER));
      eligible[i] = Req[i] && !tag_zero[i] && !Grant[i];
    end
  end

  rr_picker #(
    .N_REQ  (N_REQ),
    .PRIO_W (PRIO_W)
  ) u_picker (
    .eligible (eligible),
    .prio     (prio),
    .winner   (winner),
    .found    (found)
  );

  // No buffering: the broadcast is taken straight from the winner's inputs.
  assign win_tag  = Req_Tag[int'(winner)*TAG_W +: TAG_W];
  assign win_data = Req_Data[int'(winner)*DATA_W +: DATA_W];

  // Bus output registers and the rotating priority pointer. Priority only
  // advances past a winner; idle cycles leave it where it is.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Grant       <= '0;
      CDB_Valid   <= 1'b0;
      Qi_CDB      <= '0;
      Qi_CDB_data <= IDLE_DATA;
      Tag_Error   <= 1'b0;
      prio        <= '0;
    end else begin
      Tag_Error <= Tag_Error | (|tag_zero);
      if (found) begin
        Grant       <= N_REQ'(1) << winner;
        CDB_Valid   <= 1'b1;
        Qi_CDB      <= win_tag;
        Qi_CDB_data <= win_data;
        if (int'(winner) == N_REQ - 1) begin
          prio <= '0;
        end else begin
          prio <= winner + PRIO_W'(1);
        end
      end else begin
        Grant       <= '0;
        CDB_Valid   <= 1'b0;
        Qi_CDB      <= '0;
        Qi_CDB_data <= IDLE_DATA;
      end
    end
  end

`ifdef CDB_STATS_EN
  logic conflict;

  // Two or more bits set: clearing the lowest set bit leaves something.
  assign conflict = |(eligible & (eligible - N_REQ'(1)));

  // Saturating bus statistics; they never influence arbitration.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Bcast_Count    <= '0;
      Conflict_Count <= '0;
    end else begin
      if (found) begin
        Bcast_Count <= sat_inc16(Bcast_Count);
      end
      if (conflict) begin
        Conflict_Count <= sat_inc16(Conflict_Count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// Scoreboard bench for cdb_arbiter with three stations. The driver applies
// one input vector per cycle and pushes the response predicted by a
// behavioural round-robin model; a monitor pops and compares at each
// falling edge once the prediction is due.
module tb_cdb_arbiter;

  localparam int                N    = 3;
  localparam int                TW   = 3;
  localparam int                DW   = 16;
  localparam logic [DW-1:0]     IDLE = 16'hFFF0;

  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic [N-1:0]    Req = '0;
  logic [N*TW-1:0] Req_Tag = '0;
  logic [N*DW-1:0] Req_Data = '0;
  logic [N-1:0]    Grant;
  logic            CDB_Valid;
  logic [TW-1:0]   Qi_CDB;
  logic [DW-1:0]   Qi_CDB_data;
  logic            Tag_Error;
`ifdef CDB_STATS_EN
  logic [15:0]     Bcast_Count;
  logic [15:0]     Conflict_Count;
`endif

  cdb_arbiter #(
    .N_REQ     (N),
    .TAG_W     (TW),
    .DATA_W    (DW),
    .IDLE_DATA (IDLE)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Req         (Req),
    .Req_Tag     (Req_Tag),
    .Req_Data    (Req_Data),
    .Grant       (Grant),
    .CDB_Valid   (CDB_Valid),
    .Qi_CDB      (Qi_CDB),
    .Qi_CDB_data (Qi_CDB_data),
    .Tag_Error   (Tag_Error)
`ifdef CDB_STATS_EN
    ,
    .Bcast_Count    (Bcast_Count),
    .Conflict_Count (Conflict_Count)
`endif
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic          valid;
    logic [N-1:0]  grant;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          terr;
    logic [15:0]   bc;
    logic [15:0]   cc;
  } exp_t;

  exp_t sb[$];

  logic [TW-1:0] tag_v[N];
  logic [DW-1:0] data_v[N];

  // Reference model state: who won last cycle (-1 if nobody), who has
  // priority, and the sticky error and statistics.
  int m_last = -1;
  int m_prio = 0;
  bit m_terr = 1'b0;
  int m_bc   = 0;
  int m_cc   = 0;

  int errors = 0;
  int checks = 0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_output(input exp_t e);
    compare("grant",     32'(Grant),       32'(e.grant));
    compare("cdb_valid", 32'(CDB_Valid),   32'(e.valid));
    compare("qi_cdb",    32'(Qi_CDB),      32'(e.tag));
    compare("qi_data",   32'(Qi_CDB_data), 32'(e.data));
    compare("tag_error", 32'(Tag_Error),   32'(e.terr));
`ifdef CDB_STATS_EN
    compare("bcast_count",    32'(Bcast_Count),    32'(e.bc));
    compare("conflict_count", 32'(Conflict_Count), 32'(e.cc));
`endif
  endtask

  // Drive one cycle of inputs and predict what the bus shows after the
  // next rising edge. The winner is the eligible station with the smallest
  // circular distance from the priority index.
  task automatic apply_stimulus(input bit rst, input logic [N-1:0] req);
    exp_t e;
    int   best;
    int   best_d;
    int   d;
    int   n_elig;
    @(posedge Clock);
    #1;
    Reset = rst;
    Req   = req;
    for (int i = 0; i < N; i++) begin
      Req_Tag[i*TW +: TW]  = tag_v[i];
      Req_Data[i*DW +: DW] = data_v[i];
    end
    e.due = cyc + 1;
    if (rst) begin
      m_last = -1;
      m_prio = 0;
      m_terr = 1'b0;
      m_bc   = 0;
      m_cc   = 0;
      e.valid = 1'b0;
      e.grant = '0;
      e.tag   = '0;
      e.data  = IDLE;
    end else begin
      best   = -1;
      best_d = N;
      n_elig = 0;
      for (int i = 0; i < N; i++) begin
        if (req[i] && tag_v[i] == '0) begin
          m_terr = 1'b1;
        end else if (req[i] && i != m_last) begin
          n_elig++;
          d = (i - m_prio + N) % N;
          if (d < best_d) begin
            best_d = d;
            best   = i;
          end
        end
      end
      if (n_elig >= 2 && m_cc < 65535) m_cc++;
      if (best >= 0) begin
        e.valid = 1'b1;
        e.grant = N'(1) << best;
        e.tag   = tag_v[best];
        e.data  = data_v[best];
        m_prio  = (best + 1) % N;
        m_last  = best;
        if (m_bc < 65535) m_bc++;
      end else begin
        e.valid = 1'b0;
        e.grant = '0;
        e.tag   = '0;
        e.data  = IDLE;
        m_last  = -1;
      end
    end
    e.terr = m_terr;
    e.bc   = 16'(m_bc);
    e.cc   = 16'(m_cc);
    sb.push_back(e);
  endtask

  // Monitor: compare every prediction on the falling edge of its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      tag_v[i]  = TW'(i + 1);
      data_v[i] = '0;
    end
    apply_stimulus(1'b1, 3'b000);
    apply_stimulus(1'b1, 3'b000);

    $display("[TB] idle after reset");
    repeat (3) apply_stimulus(1'b0, 3'b000);

    $display("[TB] single request, one-cycle latency");
    tag_v[0] = 3'd1; data_v[0] = 16'h0005;
    apply_stimulus(1'b0, 3'b001);
    apply_stimulus(1'b0, 3'b000);
    apply_stimulus(1'b0, 3'b000);

    $display("[TB] two stations holding requests");
    tag_v[1] = 3'd2; data_v[0] = 16'h000A; data_v[1] = 16'h0014;
    repeat (8) apply_stimulus(1'b0, 3'b011);
    repeat (2) apply_stimulus(1'b0, 3'b000);

    $display("[TB] station 0 drops after its grant");
    apply_stimulus(1'b1, 3'b000);
    apply_stimulus(1'b0, 3'b011);
    apply_stimulus(1'b0, 3'b010);
    apply_stimulus(1'b0, 3'b000);

    $display("[TB] tag 0 request and sticky error");
    tag_v[1] = 3'd0;
    repeat (2) apply_stimulus(1'b0, 3'b010);
    tag_v[1] = 3'd2;
    repeat (3) apply_stimulus(1'b0, 3'b011);
    apply_stimulus(1'b0, 3'b000);

    $display("[TB] reset during a broadcast");
    apply_stimulus(1'b1, 3'b000);
    apply_stimulus(1'b0, 3'b111);
    apply_stimulus(1'b1, 3'b111);
    apply_stimulus(1'b0, 3'b000);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          tag_v[i]  = ($urandom_range(0, 19) == 0) ? TW'(0) : TW'($urandom_range(1, 7));
          data_v[i] = DW'($urandom);
        end
      end
      apply_stimulus($urandom_range(0, 59) == 0, N'($urandom));
    end
    apply_stimulus(1'b0, 3'b000);

    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      @(negedge Clock);
      #1;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending predictions expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter and driver for the Common Data Bus (CDB) in the Tomasulo core.
- Reservation stations that have finished execution request the bus. The arbiter grants one requester per cycle and broadcasts its tag and result for one cycle.
- The broadcast, Qi_CDB/Qi_CDB_data, is consumed by register_status and by every res_station_R.
- Sits between the reservation stations' Result/Ready side and the register_status/station operand-capture side.

Parameters:
- N_REQ, 2, number of requesting stations (legal 2..8).
- TAG_W, 3, station tag width; tag 0 = FREE_REGISTER (no producer).
- DATA_W, 16, result width.
- IDLE_DATA, 16'hFFF0, value driven on Qi_CDB_data when the bus is idle (sem_valor).

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Req  in  N_REQ  bit i = station i holds a finished result.
- Req_Tag  in  N_REQ*TAG_W  station i tag in slice [i*TAG_W +: TAG_W].
- Req_Data  in  N_REQ*DATA_W  station i result in slice [i*DATA_W +: DATA_W].
- Grant  out  N_REQ  one-hot pulse; the station may free itself.
- CDB_Valid  out  1  broadcast valid this cycle.
- Qi_CDB  out  TAG_W  broadcast tag; 0 when idle.
- Qi_CDB_data  out  DATA_W  broadcast value; IDLE_DATA when idle.
- Tag_Error  out  1  sticky flag: a Req was seen with tag 0.

Behaviour:
- Interface: one clock, Clock; reset Reset is synchronous and active-high.
- All outputs are registered. Reset values: Grant=0, CDB_Valid=0, Qi_CDB=0, Qi_CDB_data=IDLE_DATA, Tag_Error=0, Prio=0.
- Eligibility in cycle t: Req[i]=1 AND tag_i!=0 AND Grant[i]=0.
  - Grant[i]=0 masks the station granted in the previous cycle, giving it one cycle to drop Req.
- Pick: the first eligible index found scanning from Prio upward, wrapping at N_REQ-1 to 0.
- At the rising edge ending cycle t, with winner w:
  - Grant<=onehot(w), CDB_Valid<=1, Qi_CDB<=tag_w, Qi_CDB_data<=data_w.
  - Prio<=(w+1) mod N_REQ.
- With no eligible request: Grant<=0, CDB_Valid<=0, Qi_CDB<=0, Qi_CDB_data<=IDLE_DATA; Prio unchanged.
- Latency: request to broadcast is 1 cycle. Throughput is 1 broadcast per cycle when 2 or more stations request.
- Handshake: the requester holds Req, Tag and Data stable until it sees Grant[i]=1, and deasserts Req in the same cycle.
  - A requester that keeps Req asserted after its grant is treated as a new request once its mask clears. It is re-broadcast no earlier than cycle t+2.
- Tag 0 with Req=1: never granted; Tag_Error<=1, sticky until Reset.
- Simultaneous requests: round robin guarantees a waiting requester is granted within N_REQ cycles.
- Reset asserted mid-broadcast: outputs return to reset values at that edge and any in-flight broadcast is dropped. Stations are reset by the same Reset.
- No internal buffering: data is taken directly from the winner's inputs.

Optional Feature:
- Macro: CDB_STATS_EN.
- Defined: adds outputs Bcast_Count[15:0] and Conflict_Count[15:0], both saturating at 16'hFFFF and reset to 0.
  - Bcast_Count increments on each broadcast.
  - Conflict_Count increments on each cycle with 2 or more eligible requesters.
- Not defined: these ports and counters do not exist. Arbitration behaviour is identical either way.

Decomposition:
- Shared package tomasulo_pkg holds:
  - TAG_W, DATA_W;
  - FREE_REGISTER=0, RES_STATION_ADD1=1, RES_STATION_ADD2=2;
  - SEM_VALOR=16'hFFF0.
- One natural sub-module, rr_picker: combinational. Inputs are the eligible vector and Prio; outputs are the winner index and a found flag.

Test Plan:
- Reset, then Req=00 for 3 cycles -> CDB_Valid=0, Qi_CDB=0, Qi_CDB_data=16'hFFF0, Grant=00.
- Req=01, tag 1, data 16'h0005 at cycle t -> cycle t+1: CDB_Valid=1, Qi_CDB=1, Qi_CDB_data=5, Grant=01. Drop Req -> t+2 idle.
- Req=11 held continuously (tags 1,2; data 16'h000A and 16'h0014) -> broadcasts alternate tag 1,2,1,2; Grant alternates 01,10; never two consecutive grants to one station.
- Req=11 from reset, station 0 drops after its grant -> tag 1 is broadcast, then tag 2 at the next edge; Prio=0 afterwards.
- Req=10 with tag 0 -> no grant, CDB_Valid=0, Tag_Error=1, which stays 1 until Reset.
- Reset pulsed while CDB_Valid=1 -> next cycle all outputs at reset values. With CDB_STATS_EN defined, Bcast_Count=0.
